// File: rtl/sys_bus_bridge.sv
// sys_bus_bridge: CPU word-request initiator for the TC0/TC1/ODM peripheral bus with error capture and irq sync
module sys_bus_bridge #(
  parameter logic [31:0] TC0_BASE  = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE  = 32'h0000_7F10,
  parameter logic [31:0] ODM_BASE  = 32'h0000_8000,
  parameter int          ODM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output logic [5:0]  hwint,
  output logic [31:0] tc0addr,
  output logic [31:0] tc1addr,
  output logic [31:0] odmaddr,
  output logic        tc0we,
  output logic        tc1we,
  output logic        odmwe,
  output logic [31:0] tc0write,
  output logic [31:0] tc1write,
  output logic [31:0] odmwrite,
  input  logic [31:0] tc0data,
  input  logic [31:0] tc1data,
  input  logic [31:0] odmdata,
  input  logic        tc0intreq,
  input  logic        tc1intreq
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {S_NONE, S_TC0, S_TC1, S_ODM} sel_t;
  localparam logic [32:0] ODM_END = {1'b0, ODM_BASE} + 33'(ODM_WORDS * 4);
  state_t      state, state_n;
  sel_t        sel, sel_r;
  logic [31:0] a_r, rd_mux;
  logic        we_r, tc0_hit, tc1_hit, odm_hit, ro_wr, tc0_irq_r, tc1_irq_r;
  // Offset 8 of each timer is the read-only count register, so a write there is rejected
  always_comb begin
    tc0_hit = cpu_addr[31:4] == TC0_BASE[31:4] && cpu_addr[3:2] != 2'b11;
    tc1_hit = cpu_addr[31:4] == TC1_BASE[31:4] && cpu_addr[3:2] != 2'b11;
    odm_hit = cpu_addr >= ODM_BASE && {1'b0, cpu_addr} < ODM_END;
    ro_wr   = cpu_we && cpu_addr[3:2] == 2'b10;
    sel     = cpu_addr[1:0] != 2'b00 ? S_NONE :
              tc0_hit && !ro_wr       ? S_TC0  :
              tc1_hit && !ro_wr       ? S_TC1  :
              odm_hit                 ? S_ODM  : S_NONE;
    rd_mux  = we_r            ? 32'h0   :
              sel_r == S_TC0  ? tc0data :
              sel_r == S_TC1  ? tc1data :
              sel_r == S_ODM  ? odmdata : 32'h0;
    state_n = state == IDLE  ? (cpu_req ? ISSUE : IDLE) :
              state == ISSUE ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  assign cpu_busy = state != IDLE;
  assign hwint    = {4'b0000, tc1_irq_r, tc0_irq_r};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a_r       <= '0;
      we_r      <= 1'b0;
      sel_r     <= S_NONE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
      tc0_irq_r <= 1'b0;
      tc1_irq_r <= 1'b0;
      tc0addr   <= '0;
      tc1addr   <= '0;
      odmaddr   <= '0;
      tc0we     <= 1'b0;
      tc1we     <= 1'b0;
      odmwe     <= 1'b0;
      tc0write  <= '0;
      tc1write  <= '0;
      odmwrite  <= '0;
    end else begin
      tc0_irq_r <= tc0intreq;
      tc1_irq_r <= tc1intreq;
      tc0we     <= 1'b0;
      tc1we     <= 1'b0;
      odmwe     <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      if (state == IDLE && cpu_req) begin
        a_r   <= cpu_addr;
        we_r  <= cpu_we;
        sel_r <= sel;
        if (sel == S_TC0) begin
          tc0addr  <= {cpu_addr[31:2], 2'b00};
          tc0write <= cpu_wdata;
          tc0we    <= cpu_we;
        end
        if (sel == S_TC1) begin
          tc1addr  <= {cpu_addr[31:2], 2'b00};
          tc1write <= cpu_wdata;
          tc1we    <= cpu_we;
        end
        if (sel == S_ODM) begin
          odmaddr  <= {cpu_addr[31:2], 2'b00};
          odmwrite <= cpu_wdata;
          odmwe    <= cpu_we;
        end
      end
      if (state == ISSUE) begin
        cpu_ready <= 1'b1;
        cpu_rdata <= rd_mux;
        if (sel_r == S_NONE) begin
          bus_err <= 1'b1;
          if (!bus_err) err_addr <= a_r;
        end
      end
    end
endmodule
